// File: rtl/key_event_conditioner.sv
// Push-button conditioner: per-key synchronizer, ms-tick debounce, press/release
// pulses, long-press detection and auto-repeat for the clock's set keys.
package key_event_pkg;
  typedef struct packed {
    logic press;
    logic rel;
    logic rpt;
    logic level;
    logic held;
  } key_evt_t;
endpackage

module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 600,
  parameter int REPEAT_MS   = 150
) (
  input  logic     gclk,
  input  logic     rst,
  input  logic     tick,
  input  logic     key_n,
  output key_evt_t evt
);
  localparam int CNT_MAX = (DEBOUNCE_MS > HOLD_MS) ?
                           ((DEBOUNCE_MS > REPEAT_MS) ? DEBOUNCE_MS : REPEAT_MS) :
                           ((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
  localparam bit               REP_EN    = (REPEAT_MS > 0);

  typedef enum logic [2:0] {
    IDLE, DB_PRESS, PRESSED, HELD, DB_RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             ks;

  // ks is the second synchronizer stage; raw key_n never reaches the FSM
  assign ks = sync_q[1];

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      state  <= IDLE;
      cnt    <= '0;
      evt    <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      evt.press <= 1'b0;
      evt.rel   <= 1'b0;
      evt.rpt   <= 1'b0;
      case (state)
        IDLE: begin
          if (!ks) begin
            state <= DB_PRESS;
            cnt   <= '0;
          end
        end
        DB_PRESS: begin
          if (ks) begin
            state <= IDLE;
          end else if (tick) begin
            if (cnt == DB_LAST) begin
              state     <= PRESSED;
              cnt       <= '0;
              evt.press <= 1'b1;
              evt.level <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (ks) begin
            state <= DB_RELEASE;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == HOLD_LAST) begin
              state    <= HELD;
              cnt      <= '0;
              evt.held <= 1'b1;
              evt.rpt  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (ks) begin
            state <= DB_RELEASE;
            cnt   <= '0;
          end else if (REP_EN && tick) begin
            if (cnt == REP_LAST) begin
              cnt     <= '0;
              evt.rpt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          // a short high glitch returns to the pressed side with a fresh timer
          if (!ks) begin
            state <= evt.held ? HELD : PRESSED;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              evt.rel   <= 1'b1;
              evt.level <= 1'b0;
              evt.held  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module key_event_conditioner
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 600,
  parameter int REPEAT_MS   = 150
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] held
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  key_evt_t [NUM_KEYS-1:0] evt;

  // free-running 1 ms timebase shared by all channels
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .gclk (CLOCK_50),
      .rst  (RESET),
      .tick (tick),
      .key_n(KEY[g]),
      .evt  (evt[g])
    );
    assign press_pulse[g]   = evt[g].press;
    assign release_pulse[g] = evt[g].rel;
    assign repeat_pulse[g]  = evt[g].rpt;
    assign key_level[g]     = evt[g].level;
    assign held[g]          = evt[g].held;
  end
endmodule

// File: tb/tb_key_event_conditioner.sv
// Directed bench for key_event_conditioner with a 4-cycle ms tick.
module tb_key_event_conditioner;
  localparam int NK = 4;

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic [NK-1:0] KEY = 4'hF;
  logic [NK-1:0] press_pulse, release_pulse, repeat_pulse, key_level, held;

  key_event_conditioner #(
    .NUM_KEYS(NK), .TICK_DIV(4), .DEBOUNCE_MS(3), .HOLD_MS(10), .REPEAT_MS(4)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET        (RESET),
    .KEY          (KEY),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .key_level    (key_level),
    .held         (held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_fail = 0;
  int pp_cnt[NK], rp_cnt[NK], rep_cnt[NK];
  int b2b = 0;
  logic [NK-1:0] lvl_or, held_or;
  logic [NK-1:0] prev_p = '0, prev_r = '0, prev_t = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < NK; i++) begin
      pp_cnt[i] = 0; rp_cnt[i] = 0; rep_cnt[i] = 0;
    end
    lvl_or = '0;
    held_or = '0;
  endtask

  // one clock: sample outputs at the falling edge and accumulate event counts
  task automatic cyc();
    @(negedge CLOCK_50);
    for (int i = 0; i < NK; i++) begin
      pp_cnt[i]  += int'(press_pulse[i]);
      rp_cnt[i]  += int'(release_pulse[i]);
      rep_cnt[i] += int'(repeat_pulse[i]);
    end
    b2b += $countones((press_pulse & prev_p) | (release_pulse & prev_r) |
                      (repeat_pulse & prev_t));
    prev_p = press_pulse;
    prev_r = release_pulse;
    prev_t = repeat_pulse;
    lvl_or |= key_level;
    held_or |= held;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) cyc();
  endtask

  // kind: 0 press, 1 release, 2 repeat; n = cycles waited, -1 on timeout
  task automatic wait_evt(input int kind, input logic [NK-1:0] mask, input int maxc,
                          output int n, output logic [NK-1:0] v);
    logic [NK-1:0] p;
    n = -1;
    v = '0;
    for (int i = 1; i <= maxc && n < 0; i++) begin
      cyc();
      case (kind)
        0:       p = press_pulse;
        1:       p = release_pulse;
        default: p = repeat_pulse;
      endcase
      if ((p & mask) != '0) begin
        n = i;
        v = p;
      end
    end
  endtask

  initial begin
    int n;
    logic [NK-1:0] v;
    clear();

    // reset
    run(3);
    chk("rst_outputs", int'({press_pulse, release_pulse, repeat_pulse, key_level, held}), 0);
    RESET = 1'b0;
    run(8);
    chk("idle_outputs", int'({press_pulse, release_pulse, repeat_pulse, key_level, held}), 0);

    // clean press on key 1
    clear();
    KEY[1] = 1'b0;
    wait_evt(0, 4'b0010, 20, n, v);
    chk_rng("t1_press_lat", n, 11, 15);
    chk("t1_press_vec", int'(v), 2);
    chk("t1_level_same_cycle", int'(key_level), 2);
    run(15);
    chk("t1_press_cnt", pp_cnt[1], 1);
    chk("t1_other_press", pp_cnt[0] + pp_cnt[2] + pp_cnt[3], 0);
    chk("t1_no_repeat", rep_cnt[0] + rep_cnt[1] + rep_cnt[2] + rep_cnt[3], 0);
    chk("t1_no_held", int'(held_or), 0);
    chk("t1_level_or", int'(lvl_or), 2);
    KEY[1] = 1'b1;
    wait_evt(1, 4'b0010, 20, n, v);
    chk_rng("t1_release_lat", n, 11, 15);
    chk("t1_level_clear", int'(key_level), 0);
    run(5);

    // bounce reject on key 2
    clear();
    KEY[2] = 1'b0; run(6);
    KEY[2] = 1'b1; run(6);
    KEY[2] = 1'b0; run(6);
    KEY[2] = 1'b1; run(20);
    chk("t2_events", pp_cnt[2] + rp_cnt[2] + rep_cnt[2], 0);
    chk("t2_level", int'(lvl_or[2]), 0);

    // long hold on key 0
    clear();
    KEY[0] = 1'b0;
    wait_evt(0, 4'b0001, 20, n, v);
    chk_rng("t3_press_lat", n, 11, 15);
    wait_evt(2, 4'b0001, 50, n, v);
    chk("t3_hold_entry", n, 40);
    chk("t3_held", int'(held[0]), 1);
    for (int r = 0; r < 4; r++) begin
      wait_evt(2, 4'b0001, 20, n, v);
      chk("t3_repeat_gap", n, 16);
    end
    run(4);
    KEY[0] = 1'b1;
    wait_evt(1, 4'b0001, 20, n, v);
    chk_rng("t3_release_lat", n, 9, 13);
    chk("t3_held_clear", int'(held[0]), 0);
    chk("t3_level_clear", int'(key_level[0]), 0);
    chk("t3_repeat_total", rep_cnt[0], 5);
    chk("t3_press_total", pp_cnt[0], 1);
    run(5);

    // reset mid-hold
    clear();
    KEY[0] = 1'b0;
    wait_evt(0, 4'b0001, 20, n, v);
    wait_evt(2, 4'b0001, 50, n, v);
    chk("t5_hold_entry", n, 40);
    RESET = 1'b1;
    #1;
    chk("t5_rst_immediate", int'({press_pulse, release_pulse, repeat_pulse, key_level, held}), 0);
    run(2);
    chk("t5_rst_held", int'({press_pulse, release_pulse, repeat_pulse, key_level, held}), 0);
    RESET = 1'b0;
    clear();
    wait_evt(0, 4'b0001, 20, n, v);
    chk_rng("t5_repress_lat", n, 11, 15);
    wait_evt(2, 4'b0001, 50, n, v);
    chk("t5_hold_entry2", n, 40);
    chk("t5_no_release", rp_cnt[0], 0);

    // release glitch while held
    clear();
    KEY[0] = 1'b1; run(4);
    KEY[0] = 1'b0;
    wait_evt(2, 4'b0001, 30, n, v);
    chk_rng("t6_repeat_after_glitch", n, 12, 20);
    chk("t6_no_release", rp_cnt[0], 0);
    chk("t6_still_held", int'(held[0]), 1);
    KEY[0] = 1'b1;
    wait_evt(1, 4'b0001, 20, n, v);
    chk_rng("t6_release_lat", n, 11, 15);
    run(5);

    // simultaneous keys
    clear();
    KEY = 4'b0101;
    wait_evt(0, 4'hF, 20, n, v);
    chk_rng("t4_press_lat", n, 11, 15);
    chk("t4_press_vec", int'(v), 10);
    run(10);
    chk("t4_press_cnt3", pp_cnt[3], 1);
    chk("t4_press_cnt1", pp_cnt[1], 1);
    chk("t4_no_press_2_0", pp_cnt[2] + pp_cnt[0], 0);
    KEY = 4'hF;
    wait_evt(1, 4'hF, 20, n, v);
    chk("t4_release_vec", int'(v), 10);
    run(5);

    chk("no_back_to_back", b2b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
